read_input_queue: RTL and testbench
===================================

// Module: read_input_queue
// PURPOSE
//  Receiving end of the microcode->read handshake. Captures the micro_* instruction bundle whenever micro_ready
//  is high and drives rd_busy back to the microcode sequencer. Buffers up to DEPTH bundles in order and presents
//  the oldest to the read stage through a valid/accept handshake. Flushed by rd_reset: on exception, branch or
//  pipeline restart.
// PARAMETERS
//  DEPTH  2  number of buffered bundles; power of two, >= 2
// PORTS
//  clk                  in   1    clock
//  rst_n                in   1    reset, asynchronous, active-low
//  rd_reset             in   1    synchronous flush of all entries
//  micro_ready          in   1    bundle valid this cycle; already qualified by rd_busy upstream
//  micro_decoder        in   88   instruction bytes
//  micro_eip            in   32   instruction EIP
//  micro_operand_32bit  in   1    operand size 32
//  micro_address_32bit  in   1    address size 32
//  micro_prefix_group_1_rep  in 2 REP prefix
//  micro_prefix_group_1_lock in 1 LOCK prefix
//  micro_prefix_group_2_seg  in 3 segment override, 3 = none
//  micro_prefix_2byte   in   1    0x0F prefix
//  micro_consumed       in   4    instruction length
//  micro_modregrm_len   in   3    modrm/sib/disp length
//  micro_is_8bit        in   1    byte operand
//  micro_cmd            in   7    command
//  micro_cmdex          in   4    command extension
//  rd_busy              out  1    queue full; registered-state only
//  rd_valid             out  1    oldest entry present
//  rd_accept            in   1    read stage consumes oldest entry this cycle
//  rd_<field>           out  -    same 13 fields and widths as micro_<field>, taken from the oldest entry
//  rd_count             out  log2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset (rst_n=0, async): write and read pointers = 0, count = 0, rd_valid = 0, rd_busy = 0.
//    rd_cmd = CMD_NULL; all other rd_* fields = 0 except rd_prefix_group_2_seg = 3.
//  - Storage entries are not reset. Outputs are forced to the reset values whenever count == 0.
//  - push = micro_ready && !rd_busy && !rd_reset. pop = rd_valid && rd_accept && !rd_reset.
//  - rd_busy = (count == DEPTH). It is a function of registered state only: no combinational path from
//    micro_ready or rd_accept, which breaks the loop through micro_ready.
//  - micro_ready while rd_busy is a protocol violation: the bundle is dropped and a simulation assertion fires.
//  - Latency: a bundle pushed in cycle N is visible on rd_* in cycle N+1. There is no bypass when empty.
//  - Simultaneous push and pop: count is unchanged and both pointers advance. When count == 1, the next
//    cycle shows the new bundle.
//  - rd_reset has priority over push and pop. Next cycle: count = 0, pointers = 0, rd_valid = 0, rd_busy = 0.
//    A bundle presented in the same cycle as rd_reset is discarded.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count saturates in range [0, DEPTH] by construction.
//  - Order is strictly FIFO. The oldest bundle is held stable while rd_valid && !rd_accept.
//  - rd_valid = (count != 0).
// STRUCTURE
//  - Shared package/defines: CMD_NULL, bundle field widths, and a packed bundle width constant
//    (148 bits) with field offsets. Pack and unpack use these offsets.
//  - One sub-module: read_input_queue_mem, a DEPTH x 148 register array with write enable and async read.
//    Pointer, count and handshake control stay in the top.
// TESTING
//  1 Reset release, no traffic -> rd_valid=0, rd_busy=0, rd_cmd=CMD_NULL, rd_prefix_group_2_seg=3, rd_count=0.
//  2 Push cmd=0x12 eip=0x1000, then cmd=0x13 eip=0x1004, rd_accept=0 -> rd_busy=1 after the second push;
//    rd_eip stays 0x1000 for 5 cycles.
//  3 Full queue, rd_accept=1 for one cycle -> rd_busy=0 next cycle, rd_eip=0x1004, rd_count=1.
//  4 count=1 (eip 0x2000), push eip 0x2004 with pop in the same cycle -> next cycle rd_eip=0x2004, rd_count=1.
//  5 count=2, rd_reset=1 with micro_ready=1 (eip 0x3000) -> next cycle rd_valid=0, rd_count=0;
//    0x3000 never appears on rd_eip.
//  6 Random push/accept for 10k cycles vs a scoreboard -> order and fields match, no drops while rd_busy=0.
//    Assert rst_n mid-stream -> outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/read_input_queue_pkg.sv
// Shared definitions for the read input queue: command constants, bundle field widths,
// the packed bundle layout and the pack/unpack helpers that use it.
package read_input_queue_pkg;

  localparam logic [6:0] CMD_NULL = 7'd0;
  localparam logic [2:0] SEG_NONE = 3'd3;

  // Field widths of one microcode bundle.
  localparam int unsigned W_DECODER      = 88;
  localparam int unsigned W_EIP          = 32;
  localparam int unsigned W_OPERAND_32   = 1;
  localparam int unsigned W_ADDRESS_32   = 1;
  localparam int unsigned W_REP          = 2;
  localparam int unsigned W_LOCK         = 1;
  localparam int unsigned W_SEG          = 3;
  localparam int unsigned W_PREFIX_2BYTE = 1;
  localparam int unsigned W_CONSUMED     = 4;
  localparam int unsigned W_MODREGRM_LEN = 3;
  localparam int unsigned W_IS_8BIT      = 1;
  localparam int unsigned W_CMD          = 7;
  localparam int unsigned W_CMDEX        = 4;

  // Bit offsets inside the packed storage word, LSB first.
  localparam int unsigned OFF_CMDEX        = 0;
  localparam int unsigned OFF_CMD          = OFF_CMDEX + W_CMDEX;
  localparam int unsigned OFF_IS_8BIT      = OFF_CMD + W_CMD;
  localparam int unsigned OFF_MODREGRM_LEN = OFF_IS_8BIT + W_IS_8BIT;
  localparam int unsigned OFF_CONSUMED     = OFF_MODREGRM_LEN + W_MODREGRM_LEN;
  localparam int unsigned OFF_PREFIX_2BYTE = OFF_CONSUMED + W_CONSUMED;
  localparam int unsigned OFF_SEG          = OFF_PREFIX_2BYTE + W_PREFIX_2BYTE;
  localparam int unsigned OFF_LOCK         = OFF_SEG + W_SEG;
  localparam int unsigned OFF_REP          = OFF_LOCK + W_LOCK;
  localparam int unsigned OFF_ADDRESS_32   = OFF_REP + W_REP;
  localparam int unsigned OFF_OPERAND_32   = OFF_ADDRESS_32 + W_ADDRESS_32;
  localparam int unsigned OFF_EIP          = OFF_OPERAND_32 + W_OPERAND_32;
  localparam int unsigned OFF_DECODER      = OFF_EIP + W_EIP;
  localparam int unsigned BUNDLE_W         = OFF_DECODER + W_DECODER;  // 148

  typedef struct packed {
    logic [W_DECODER-1:0]      decoder;
    logic [W_EIP-1:0]          eip;
    logic                      operand_32bit;
    logic                      address_32bit;
    logic [W_REP-1:0]          prefix_group_1_rep;
    logic                      prefix_group_1_lock;
    logic [W_SEG-1:0]          prefix_group_2_seg;
    logic                      prefix_2byte;
    logic [W_CONSUMED-1:0]     consumed;
    logic [W_MODREGRM_LEN-1:0] modregrm_len;
    logic                      is_8bit;
    logic [W_CMD-1:0]          cmd;
    logic [W_CMDEX-1:0]        cmdex;
  } bundle_t;

  // Value presented on the read side while the queue is empty.
  function automatic bundle_t reset_bundle();
    bundle_t b;
    b                    = '0;
    b.cmd                = CMD_NULL;
    b.prefix_group_2_seg = SEG_NONE;
    return b;
  endfunction

  function automatic logic [BUNDLE_W-1:0] pack_bundle(input bundle_t b);
    logic [BUNDLE_W-1:0] v;
    v                                        = '0;
    v[OFF_CMDEX        +: W_CMDEX]           = b.cmdex;
    v[OFF_CMD          +: W_CMD]             = b.cmd;
    v[OFF_IS_8BIT      +: W_IS_8BIT]         = b.is_8bit;
    v[OFF_MODREGRM_LEN +: W_MODREGRM_LEN]    = b.modregrm_len;
    v[OFF_CONSUMED     +: W_CONSUMED]        = b.consumed;
    v[OFF_PREFIX_2BYTE +: W_PREFIX_2BYTE]    = b.prefix_2byte;
    v[OFF_SEG          +: W_SEG]             = b.prefix_group_2_seg;
    v[OFF_LOCK         +: W_LOCK]            = b.prefix_group_1_lock;
    v[OFF_REP          +: W_REP]             = b.prefix_group_1_rep;
    v[OFF_ADDRESS_32   +: W_ADDRESS_32]      = b.address_32bit;
    v[OFF_OPERAND_32   +: W_OPERAND_32]      = b.operand_32bit;
    v[OFF_EIP          +: W_EIP]             = b.eip;
    v[OFF_DECODER      +: W_DECODER]         = b.decoder;
    return v;
  endfunction

  function automatic bundle_t unpack_bundle(input logic [BUNDLE_W-1:0] v);
    bundle_t b;
    b.cmdex               = v[OFF_CMDEX        +: W_CMDEX];
    b.cmd                 = v[OFF_CMD          +: W_CMD];
    b.is_8bit             = v[OFF_IS_8BIT      +: W_IS_8BIT];
    b.modregrm_len        = v[OFF_MODREGRM_LEN +: W_MODREGRM_LEN];
    b.consumed            = v[OFF_CONSUMED     +: W_CONSUMED];
    b.prefix_2byte        = v[OFF_PREFIX_2BYTE +: W_PREFIX_2BYTE];
    b.prefix_group_2_seg  = v[OFF_SEG          +: W_SEG];
    b.prefix_group_1_lock = v[OFF_LOCK         +: W_LOCK];
    b.prefix_group_1_rep  = v[OFF_REP          +: W_REP];
    b.address_32bit       = v[OFF_ADDRESS_32   +: W_ADDRESS_32];
    b.operand_32bit       = v[OFF_OPERAND_32   +: W_OPERAND_32];
    b.eip                 = v[OFF_EIP          +: W_EIP];
    b.decoder             = v[OFF_DECODER      +: W_DECODER];
    return b;
  endfunction

endpackage

// File: rtl/read_input_queue_mem.sv
// Storage array for the read input queue: DEPTH words, one write port, asynchronous read.
// Entries carry no reset; the top masks the read data while the queue is empty.
module read_input_queue_mem #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 148
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry on push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/read_input_queue.sv
// Read input queue: buffers microcode bundles in FIFO order and presents the oldest one to the
// read stage with a valid/accept handshake. rd_busy depends on registered occupancy only.
module read_input_queue
  import read_input_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_reset,

  input  logic                      micro_ready,
  input  logic [87:0]               micro_decoder,
  input  logic [31:0]               micro_eip,
  input  logic                      micro_operand_32bit,
  input  logic                      micro_address_32bit,
  input  logic [1:0]                micro_prefix_group_1_rep,
  input  logic                      micro_prefix_group_1_lock,
  input  logic [2:0]                micro_prefix_group_2_seg,
  input  logic                      micro_prefix_2byte,
  input  logic [3:0]                micro_consumed,
  input  logic [2:0]                micro_modregrm_len,
  input  logic                      micro_is_8bit,
  input  logic [6:0]                micro_cmd,
  input  logic [3:0]                micro_cmdex,

  output logic                      rd_busy,
  output logic                      rd_valid,
  input  logic                      rd_accept,

  output logic [87:0]               rd_decoder,
  output logic [31:0]               rd_eip,
  output logic                      rd_operand_32bit,
  output logic                      rd_address_32bit,
  output logic [1:0]                rd_prefix_group_1_rep,
  output logic                      rd_prefix_group_1_lock,
  output logic [2:0]                rd_prefix_group_2_seg,
  output logic                      rd_prefix_2byte,
  output logic [3:0]                rd_consumed,
  output logic [2:0]                rd_modregrm_len,
  output logic                      rd_is_8bit,
  output logic [6:0]                rd_cmd,
  output logic [3:0]                rd_cmdex,
  output logic [$clog2(DEPTH):0]    rd_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;
  logic empty;

  bundle_t             wr_bundle;
  bundle_t             head_bundle;
  bundle_t             out_bundle;
  logic [BUNDLE_W-1:0] wr_data;
  logic [BUNDLE_W-1:0] rd_data;

  // Status is derived from the occupancy register alone, so nothing here depends on
  // micro_ready or rd_accept combinationally.
  assign empty    = (count_q == '0);
  assign rd_valid = !empty;
  assign rd_busy  = (count_q == CNT_W'(DEPTH));
  assign rd_count = count_q;

  // Flush wins over both sides of the handshake.
  assign push = micro_ready && !rd_busy && !rd_reset;
  assign pop  = rd_valid && rd_accept && !rd_reset;

  // Gather the incoming fields into one bundle and pack for storage.
  always_comb begin
    wr_bundle                     = '0;
    wr_bundle.decoder             = micro_decoder;
    wr_bundle.eip                 = micro_eip;
    wr_bundle.operand_32bit       = micro_operand_32bit;
    wr_bundle.address_32bit       = micro_address_32bit;
    wr_bundle.prefix_group_1_rep  = micro_prefix_group_1_rep;
    wr_bundle.prefix_group_1_lock = micro_prefix_group_1_lock;
    wr_bundle.prefix_group_2_seg  = micro_prefix_group_2_seg;
    wr_bundle.prefix_2byte        = micro_prefix_2byte;
    wr_bundle.consumed            = micro_consumed;
    wr_bundle.modregrm_len        = micro_modregrm_len;
    wr_bundle.is_8bit             = micro_is_8bit;
    wr_bundle.cmd                 = micro_cmd;
    wr_bundle.cmdex               = micro_cmdex;
  end

  assign wr_data = pack_bundle(wr_bundle);

  read_input_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (BUNDLE_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Next-state for pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rd_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset, so an empty queue shows the idle bundle instead of stale data.
  always_comb begin
    head_bundle = unpack_bundle(rd_data);
    out_bundle  = empty ? reset_bundle() : head_bundle;
  end

  assign rd_decoder             = out_bundle.decoder;
  assign rd_eip                 = out_bundle.eip;
  assign rd_operand_32bit       = out_bundle.operand_32bit;
  assign rd_address_32bit       = out_bundle.address_32bit;
  assign rd_prefix_group_1_rep  = out_bundle.prefix_group_1_rep;
  assign rd_prefix_group_1_lock = out_bundle.prefix_group_1_lock;
  assign rd_prefix_group_2_seg  = out_bundle.prefix_group_2_seg;
  assign rd_prefix_2byte        = out_bundle.prefix_2byte;
  assign rd_consumed            = out_bundle.consumed;
  assign rd_modregrm_len        = out_bundle.modregrm_len;
  assign rd_is_8bit             = out_bundle.is_8bit;
  assign rd_cmd                 = out_bundle.cmd;
  assign rd_cmdex               = out_bundle.cmdex;

  // The sequencer must hold off while busy; a bundle offered then is dropped. A flush
  // cycle discards the bundle anyway, so it is not treated as a violation.
  always @(posedge clk) begin
    if (rst_n && !rd_reset) begin
      assert (!(micro_ready && rd_busy))
        else $error("read_input_queue: micro_ready asserted while rd_busy");
    end
  end

endmodule

// File: tb/tb_read_input_queue.sv
// Self-checking bench for read_input_queue: directed scenarios followed by randomized
// push/accept/flush traffic checked by a queue-based scoreboard.
module tb_read_input_queue;

  localparam int unsigned DEPTH = 2;
  localparam logic [6:0] EXP_CMD_NULL = 7'h00;

  typedef logic [147:0] vec_t;

  typedef struct packed {
    logic [87:0] decoder;
    logic [31:0] eip;
    logic        op32;
    logic        addr32;
    logic [1:0]  rep;
    logic        lock;
    logic [2:0]  seg;
    logic        p2byte;
    logic [3:0]  consumed;
    logic [2:0]  mrm_len;
    logic        is_8bit;
    logic [6:0]  cmd;
    logic [3:0]  cmdex;
  } tb_bundle_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_reset = 1'b0;
  logic micro_ready = 1'b0;
  logic rd_accept = 1'b0;
  tb_bundle_t drv_b = '0;

  logic [87:0] micro_decoder;
  logic [31:0] micro_eip;
  logic        micro_operand_32bit, micro_address_32bit;
  logic [1:0]  micro_prefix_group_1_rep;
  logic        micro_prefix_group_1_lock;
  logic [2:0]  micro_prefix_group_2_seg;
  logic        micro_prefix_2byte;
  logic [3:0]  micro_consumed;
  logic [2:0]  micro_modregrm_len;
  logic        micro_is_8bit;
  logic [6:0]  micro_cmd;
  logic [3:0]  micro_cmdex;

  logic        rd_busy, rd_valid;
  logic [87:0] rd_decoder;
  logic [31:0] rd_eip;
  logic        rd_operand_32bit, rd_address_32bit;
  logic [1:0]  rd_prefix_group_1_rep;
  logic        rd_prefix_group_1_lock;
  logic [2:0]  rd_prefix_group_2_seg;
  logic        rd_prefix_2byte;
  logic [3:0]  rd_consumed;
  logic [2:0]  rd_modregrm_len;
  logic        rd_is_8bit;
  logic [6:0]  rd_cmd;
  logic [3:0]  rd_cmdex;
  logic [$clog2(DEPTH):0] rd_count;
  tb_bundle_t  rd_vec;

  assign {micro_decoder, micro_eip, micro_operand_32bit, micro_address_32bit,
          micro_prefix_group_1_rep, micro_prefix_group_1_lock, micro_prefix_group_2_seg,
          micro_prefix_2byte, micro_consumed, micro_modregrm_len, micro_is_8bit,
          micro_cmd, micro_cmdex} = drv_b;

  assign rd_vec = {rd_decoder, rd_eip, rd_operand_32bit, rd_address_32bit,
                   rd_prefix_group_1_rep, rd_prefix_group_1_lock, rd_prefix_group_2_seg,
                   rd_prefix_2byte, rd_consumed, rd_modregrm_len, rd_is_8bit,
                   rd_cmd, rd_cmdex};

  read_input_queue #(.DEPTH(DEPTH)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .rd_reset                  (rd_reset),
    .micro_ready               (micro_ready),
    .micro_decoder             (micro_decoder),
    .micro_eip                 (micro_eip),
    .micro_operand_32bit       (micro_operand_32bit),
    .micro_address_32bit       (micro_address_32bit),
    .micro_prefix_group_1_rep  (micro_prefix_group_1_rep),
    .micro_prefix_group_1_lock (micro_prefix_group_1_lock),
    .micro_prefix_group_2_seg  (micro_prefix_group_2_seg),
    .micro_prefix_2byte        (micro_prefix_2byte),
    .micro_consumed            (micro_consumed),
    .micro_modregrm_len        (micro_modregrm_len),
    .micro_is_8bit             (micro_is_8bit),
    .micro_cmd                 (micro_cmd),
    .micro_cmdex               (micro_cmdex),
    .rd_busy                   (rd_busy),
    .rd_valid                  (rd_valid),
    .rd_accept                 (rd_accept),
    .rd_decoder                (rd_decoder),
    .rd_eip                    (rd_eip),
    .rd_operand_32bit          (rd_operand_32bit),
    .rd_address_32bit          (rd_address_32bit),
    .rd_prefix_group_1_rep     (rd_prefix_group_1_rep),
    .rd_prefix_group_1_lock    (rd_prefix_group_1_lock),
    .rd_prefix_group_2_seg     (rd_prefix_group_2_seg),
    .rd_prefix_2byte           (rd_prefix_2byte),
    .rd_consumed               (rd_consumed),
    .rd_modregrm_len           (rd_modregrm_len),
    .rd_is_8bit                (rd_is_8bit),
    .rd_cmd                    (rd_cmd),
    .rd_cmdex                  (rd_cmdex),
    .rd_count                  (rd_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;
  tb_bundle_t exp_q[$];
  tb_bundle_t idle_b;

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic tb_bundle_t rand_bundle();
    tb_bundle_t b;
    logic [95:0] wide;
    wide      = {$urandom(), $urandom(), $urandom()};
    b.decoder = wide[87:0];
    b.eip     = $urandom();
    b.op32    = 1'($urandom());
    b.addr32  = 1'($urandom());
    b.rep     = 2'($urandom());
    b.lock    = 1'($urandom());
    b.seg     = 3'($urandom());
    b.p2byte  = 1'($urandom());
    b.consumed = 4'($urandom());
    b.mrm_len = 3'($urandom());
    b.is_8bit = 1'($urandom());
    b.cmd     = 7'($urandom());
    b.cmdex   = 4'($urandom());
    return b;
  endfunction

  task automatic set_bundle(input logic [6:0] cmd, input logic [31:0] eip);
    tb_bundle_t b;
    b     = rand_bundle();
    b.cmd = cmd;
    b.eip = eip;
    drv_b = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: occupancy and the head bundle must match the model every cycle;
  // the head is retired when the read stage accepts it.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("sb_count", vec_t'(rd_count), vec_t'(exp_q.size()));
      chk("sb_busy", vec_t'(rd_busy), vec_t'(exp_q.size() == DEPTH));
      chk("sb_valid", vec_t'(rd_valid), vec_t'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("sb_head", vec_t'(rd_vec), vec_t'(exp_q[0]));
        if (rd_accept && !rd_reset) void'(exp_q.pop_front());
      end else begin
        chk("sb_idle", vec_t'(rd_vec), vec_t'(idle_b));
      end
    end
  end

  initial begin
    bit cur_push;
    bit cur_reset;
    int acc_pct;

    idle_b     = '0;
    idle_b.cmd = EXP_CMD_NULL;
    idle_b.seg = 3'd3;

    // 1: reset release, no traffic
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("t1_valid", vec_t'(rd_valid), vec_t'(0));
    chk("t1_busy", vec_t'(rd_busy), vec_t'(0));
    chk("t1_cmd", vec_t'(rd_cmd), vec_t'(EXP_CMD_NULL));
    chk("t1_seg", vec_t'(rd_prefix_group_2_seg), vec_t'(3));
    chk("t1_count", vec_t'(rd_count), vec_t'(0));
    chk("t1_all", vec_t'(rd_vec), vec_t'(idle_b));

    // 2: two pushes with no accept fill the queue; head stays put
    next_cycle();
    set_bundle(7'h12, 32'h1000);
    micro_ready = 1'b1;
    @(negedge clk);
    chk("t2_no_bypass", vec_t'(rd_valid), vec_t'(0));
    next_cycle();
    set_bundle(7'h13, 32'h1004);
    @(negedge clk);
    chk("t2_latency_eip", vec_t'(rd_eip), vec_t'(32'h1000));
    chk("t2_latency_cmd", vec_t'(rd_cmd), vec_t'(7'h12));
    next_cycle();
    micro_ready = 1'b0;
    @(negedge clk);
    chk("t2_busy", vec_t'(rd_busy), vec_t'(1));
    chk("t2_count", vec_t'(rd_count), vec_t'(2));
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_eip", vec_t'(rd_eip), vec_t'(32'h1000));
      @(negedge clk);
    end

    // 3: one accept on a full queue
    next_cycle();
    rd_accept = 1'b1;
    next_cycle();
    rd_accept = 1'b0;
    @(negedge clk);
    chk("t3_busy", vec_t'(rd_busy), vec_t'(0));
    chk("t3_eip", vec_t'(rd_eip), vec_t'(32'h1004));
    chk("t3_cmd", vec_t'(rd_cmd), vec_t'(7'h13));
    chk("t3_count", vec_t'(rd_count), vec_t'(1));

    // 4: flush, then count=1 with simultaneous push and pop
    next_cycle();
    rd_reset = 1'b1;
    next_cycle();
    rd_reset = 1'b0;
    @(negedge clk);
    chk("t4_flush_count", vec_t'(rd_count), vec_t'(0));
    next_cycle();
    set_bundle(7'h20, 32'h2000);
    micro_ready = 1'b1;
    next_cycle();
    set_bundle(7'h21, 32'h2004);
    rd_accept = 1'b1;
    @(negedge clk);
    chk("t4_pre_eip", vec_t'(rd_eip), vec_t'(32'h2000));
    chk("t4_pre_count", vec_t'(rd_count), vec_t'(1));
    next_cycle();
    micro_ready = 1'b0;
    rd_accept   = 1'b0;
    @(negedge clk);
    chk("t4_eip", vec_t'(rd_eip), vec_t'(32'h2004));
    chk("t4_count", vec_t'(rd_count), vec_t'(1));

    // 5: flush on a full queue with a bundle offered in the same cycle
    next_cycle();
    set_bundle(7'h22, 32'h2008);
    micro_ready = 1'b1;
    next_cycle();
    set_bundle(7'h30, 32'h3000);
    rd_reset = 1'b1;
    @(negedge clk);
    chk("t5_pre_count", vec_t'(rd_count), vec_t'(2));
    next_cycle();
    micro_ready = 1'b0;
    rd_reset    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_valid", vec_t'(rd_valid), vec_t'(0));
      chk("t5_count", vec_t'(rd_count), vec_t'(0));
      chk("t5_eip", vec_t'(rd_eip), vec_t'(0));
    end

    // 6: randomized traffic against the scoreboard
    cur_push  = 1'b0;
    cur_reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      if (cur_reset) exp_q.delete();
      else if (cur_push) exp_q.push_back(drv_b);
      #1;
      mon_en    = 1'b1;
      acc_pct   = ((i / 500) % 3 == 0) ? 20 : (((i / 500) % 3 == 1) ? 60 : 95);
      cur_reset = ($urandom_range(0, 199) == 0);
      cur_push  = (exp_q.size() < DEPTH) && ($urandom_range(0, 99) < 70);
      drv_b       = rand_bundle();
      micro_ready = cur_push;
      rd_reset    = cur_reset;
      rd_accept   = ($urandom_range(0, 99) < acc_pct);
    end

    // Make sure the queue holds something, then reset asynchronously mid-cycle.
    @(posedge clk);
    if (cur_reset) exp_q.delete();
    else if (cur_push) exp_q.push_back(drv_b);
    #1;
    cur_push    = (exp_q.size() < DEPTH);
    cur_reset   = 1'b0;
    drv_b       = rand_bundle();
    micro_ready = cur_push;
    rd_reset    = 1'b0;
    rd_accept   = 1'b0;
    @(posedge clk);
    if (cur_push) exp_q.push_back(drv_b);
    #1;
    mon_en      = 1'b0;
    micro_ready = 1'b0;
    chk("t6_pre_valid", vec_t'(rd_valid), vec_t'(1));
    chk("t6_pre_count", vec_t'(rd_count), vec_t'(exp_q.size()));
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", vec_t'(rd_valid), vec_t'(0));
    chk("t6_rst_busy", vec_t'(rd_busy), vec_t'(0));
    chk("t6_rst_count", vec_t'(rd_count), vec_t'(0));
    chk("t6_rst_bundle", vec_t'(rd_vec), vec_t'(idle_b));
    exp_q.delete();
    #20 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_valid", vec_t'(rd_valid), vec_t'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
